// File: rtl/mrv1_rf_wb_arb.sv
// Register file write-port controller: round-robin writeback arbitration plus thread zeroing sweeps.
// Define MRV1_RF_INIT_CLEAR_EN to zero every thread's registers after each reset release.
module mrv1_rf_wb_arb #(
    parameter int DATA_WIDTH_P    = 32,
    parameter int NUM_TW_P        = 8,
    parameter int rf_addr_width_p = 5,
    parameter int NUM_REQ_P       = 3,
    localparam int twid_width_lp  = $clog2(NUM_TW_P)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NUM_REQ_P-1:0]                 req_valid_i,
    output logic [NUM_REQ_P-1:0]                 req_ready_o,
    input  logic [NUM_REQ_P*twid_width_lp-1:0]   req_twid_i,
    input  logic [NUM_REQ_P*rf_addr_width_p-1:0] req_addr_i,
    input  logic [NUM_REQ_P*DATA_WIDTH_P-1:0]    req_data_i,
    input  logic                                 clr_valid_i,
    input  logic [twid_width_lp-1:0]             clr_twid_i,
    output logic                                 clr_ready_o,
    output logic                                 busy_o,
    output logic [twid_width_lp-1:0]             rd_twid_o,
    output logic                                 rd_w_en_o,
    output logic [rf_addr_width_p-1:0]           rd_addr_o,
    output logic [DATA_WIDTH_P-1:0]              rd_data_o
);

    localparam int ptr_width_lp = $clog2(NUM_REQ_P);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        THR_CLEAR  = 2'd1
`ifdef MRV1_RF_INIT_CLEAR_EN
        ,INIT_CLEAR = 2'd2
`endif
    } state_e;

`ifdef MRV1_RF_INIT_CLEAR_EN
    localparam state_e reset_state_lp = INIT_CLEAR;
    logic [twid_width_lp+rf_addr_width_p-1:0] init_cnt_q;
`else
    localparam state_e reset_state_lp = RUN;
`endif

    state_e                        state_q, state_d;
    logic [rf_addr_width_p-1:0]    thr_cnt_q;
    logic [twid_width_lp-1:0]      clr_twid_q;
    logic [ptr_width_lp-1:0]       last_grant_q;
    logic [ptr_width_lp-1:0]       grant_idx;
    logic                          grant_vld;
    int unsigned                   cand;
    logic                          run_active, arb_en, wb_hs, clr_hs;
    logic [twid_width_lp-1:0]      sel_twid;
    logic [rf_addr_width_p-1:0]    sel_addr;
    logic [DATA_WIDTH_P-1:0]       sel_data;
    logic                          rd_w_en_d;
    logic [twid_width_lp-1:0]      rd_twid_d;
    logic [rf_addr_width_p-1:0]    rd_addr_d;
    logic [DATA_WIDTH_P-1:0]       rd_data_d;

    // Search starts one past the last accepted requester, wrapping at NUM_REQ_P.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int unsigned k = 1; k <= NUM_REQ_P; k++) begin
            cand = 32'(last_grant_q) + k;
            if (cand >= NUM_REQ_P) cand = cand - NUM_REQ_P;
            if (!grant_vld && req_valid_i[cand[ptr_width_lp-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[ptr_width_lp-1:0];
            end
        end
    end

    // Readies are held low while reset is asserted, whatever state it forces.
    assign run_active  = rst_i && (state_q == RUN);
    assign arb_en      = run_active && !clr_valid_i;
    assign wb_hs       = arb_en && grant_vld;
    assign clr_hs      = run_active && clr_valid_i;
    assign clr_ready_o = run_active;
    assign busy_o      = (state_q != RUN);
    assign req_ready_o = wb_hs ? (NUM_REQ_P'(1) << grant_idx) : '0;

    assign sel_twid = req_twid_i[grant_idx*twid_width_lp +: twid_width_lp];
    assign sel_addr = req_addr_i[grant_idx*rf_addr_width_p +: rf_addr_width_p];
    assign sel_data = req_data_i[grant_idx*DATA_WIDTH_P +: DATA_WIDTH_P];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= reset_state_lp;
            thr_cnt_q    <= '0;
            clr_twid_q   <= '0;
            last_grant_q <= ptr_width_lp'(NUM_REQ_P - 1);
            rd_w_en_o    <= 1'b0;
            rd_twid_o    <= '0;
            rd_addr_o    <= '0;
            rd_data_o    <= '0;
`ifdef MRV1_RF_INIT_CLEAR_EN
            init_cnt_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            rd_w_en_o <= rd_w_en_d;
            rd_twid_o <= rd_twid_d;
            rd_addr_o <= rd_addr_d;
            rd_data_o <= rd_data_d;
            thr_cnt_q <= (state_q == THR_CLEAR) ? thr_cnt_q + 1'b1 : '0;
            if (wb_hs) last_grant_q <= grant_idx;
            if (clr_hs) clr_twid_q <= clr_twid_i;
`ifdef MRV1_RF_INIT_CLEAR_EN
            init_cnt_q <= (state_q == INIT_CLEAR) ? init_cnt_q + 1'b1 : '0;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:       if (clr_valid_i) state_d = THR_CLEAR;
            THR_CLEAR: if (thr_cnt_q == '1) state_d = RUN;
`ifdef MRV1_RF_INIT_CLEAR_EN
            INIT_CLEAR: if (init_cnt_q == '1) state_d = RUN;
`endif
            default:   state_d = RUN;
        endcase
    end

    // Next values of the registered write port; fields hold when no write is issued.
    always_comb begin
        rd_w_en_d = 1'b0;
        rd_twid_d = rd_twid_o;
        rd_addr_d = rd_addr_o;
        rd_data_d = rd_data_o;
        case (state_q)
            RUN: begin
                if (wb_hs) begin
                    rd_w_en_d = (sel_addr != '0);
                    rd_twid_d = sel_twid;
                    rd_addr_d = sel_addr;
                    rd_data_d = sel_data;
                end
            end
            THR_CLEAR: begin
                rd_w_en_d = 1'b1;
                rd_twid_d = clr_twid_q;
                rd_addr_d = thr_cnt_q;
                rd_data_d = '0;
            end
`ifdef MRV1_RF_INIT_CLEAR_EN
            INIT_CLEAR: begin
                rd_w_en_d              = 1'b1;
                {rd_twid_d, rd_addr_d} = init_cnt_q;
                rd_data_d              = '0;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mrv1_rf_wb_arb.sv
// Randomised and directed bench for mrv1_rf_wb_arb against a queue-based write-port model.
// Follows MRV1_RF_INIT_CLEAR_EN the same way the design does.
module tb_mrv1_rf_wb_arb;
    localparam int DW  = 32;
    localparam int NTW = 8;
    localparam int AW  = 5;
    localparam int NR  = 3;
    localparam int TWW = 3;
`ifdef MRV1_RF_INIT_CLEAR_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_i;
    logic [NR-1:0]     req_valid_i, req_ready_o;
    logic [NR*TWW-1:0] req_twid_i;
    logic [NR*AW-1:0]  req_addr_i;
    logic [NR*DW-1:0]  req_data_i;
    logic              clr_valid_i, clr_ready_o, busy_o;
    logic [TWW-1:0]    clr_twid_i, rd_twid_o;
    logic              rd_w_en_o;
    logic [AW-1:0]     rd_addr_o;
    logic [DW-1:0]     rd_data_o;

    always #5 clk = ~clk;

    mrv1_rf_wb_arb #(
        .DATA_WIDTH_P(DW), .NUM_TW_P(NTW), .rf_addr_width_p(AW), .NUM_REQ_P(NR)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_twid_i(req_twid_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
        .clr_valid_i(clr_valid_i), .clr_twid_i(clr_twid_i), .clr_ready_o(clr_ready_o),
        .busy_o(busy_o),
        .rd_twid_o(rd_twid_o), .rd_w_en_o(rd_w_en_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of pending zero writes stands for any clear sweep in progress.
    typedef struct packed {
        logic [TWW-1:0] twid;
        logic [AW-1:0]  addr;
    } zw_t;

    zw_t            pend[$];
    logic           m_we;
    logic [TWW-1:0] m_twid;
    logic [AW-1:0]  m_addr;
    logic [DW-1:0]  m_data;
    int             m_ptr;

    function automatic int pick();
        for (int k = 1; k <= NR; k++) begin
            int i;
            i = (m_ptr + k) % NR;
            if (req_valid_i[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        pend.delete();
        m_we = 1'b0; m_twid = '0; m_addr = '0; m_data = '0;
        m_ptr = NR - 1;
`ifdef MRV1_RF_INIT_CLEAR_EN
        for (int i = 0; i < NTW * (1 << AW); i++) pend.push_back(zw_t'(i[TWW+AW-1:0]));
`endif
    endtask

    task automatic step();
        int             w;
        logic           busy;
        logic [NR-1:0]  exp_rdy;
        zw_t            z;
        @(negedge clk);
        chk("rd_w_en", rd_w_en_o, m_we);
        if (m_we) begin
            chk("rd_twid", rd_twid_o, m_twid);
            chk("rd_addr", rd_addr_o, m_addr);
            chk("rd_data", rd_data_o, m_data);
        end
        busy = (pend.size() != 0);
        chk("busy", busy_o, busy);
        exp_rdy = '0;
        w = -1;
        if (!busy && !clr_valid_i) begin
            w = pick();
            if (w >= 0) exp_rdy[w] = 1'b1;
        end
        chk("req_ready", req_ready_o, exp_rdy);
        if (busy) chk("clr_ready_busy", clr_ready_o, 0);
        else if (clr_valid_i) chk("clr_ready_run", clr_ready_o, 1);
        if (busy) begin
            z = pend.pop_front();
            m_we = 1'b1; m_twid = z.twid; m_addr = z.addr; m_data = '0;
        end else if (clr_valid_i) begin
            m_we = 1'b0;
            for (int a = 0; a < (1 << AW); a++) pend.push_back(zw_t'({clr_twid_i, AW'(a)}));
        end else if (w >= 0) begin
            m_addr = req_addr_i[w*AW +: AW];
            m_twid = req_twid_i[w*TWW +: TWW];
            m_data = req_data_i[w*DW +: DW];
            m_we   = (m_addr != 0);
            m_ptr  = w;
        end else begin
            m_we = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs(input int clr_pct);
        req_valid_i = NR'($urandom);
        for (int i = 0; i < NR; i++) begin
            req_twid_i[i*TWW +: TWW] = TWW'($urandom);
            req_addr_i[i*AW +: AW]   = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
            req_data_i[i*DW +: DW]   = $urandom;
        end
        clr_valid_i = ($urandom_range(0, 99) < clr_pct);
        clr_twid_i  = TWW'($urandom);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rd_w_en"}, rd_w_en_o, 0);
        chk({tag, "_rd_twid"}, rd_twid_o, 0);
        chk({tag, "_rd_addr"}, rd_addr_o, 0);
        chk({tag, "_rd_data"}, rd_data_o, 0);
        chk({tag, "_req_ready"}, req_ready_o, 0);
        chk({tag, "_clr_ready"}, clr_ready_o, 0);
        chk({tag, "_busy"}, busy_o, INIT_EN);
    endtask

    logic [NR-1:0] seq [6];
    logic [NR-1:0] seq_exp [6];
    int            cnt;

    initial begin
        seq_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        rst_i = 1'b0;
        req_valid_i = '1; clr_valid_i = 1'b1; clr_twid_i = '0;
        for (int i = 0; i < NR; i++) begin
            req_twid_i[i*TWW +: TWW] = TWW'(i + 1);
            req_addr_i[i*AW +: AW]   = AW'(i + 1);
            req_data_i[i*DW +: DW]   = 32'h1000 + i;
        end
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("por");
        req_valid_i = '0; clr_valid_i = 1'b0;
        rst_i = 1'b1;
        model_reset();

`ifdef MRV1_RF_INIT_CLEAR_EN
        cnt = 0;
        for (int j = 1; j <= 257; j++) begin
            step();
            if (rd_w_en_o && rd_data_o == 0 && {rd_twid_o, rd_addr_o} == (j - 1)) cnt++;
        end
        chk("init_sweep_writes", cnt, 256);
        chk("init_sweep_done_busy", busy_o, 0);
`endif

        // Single requester 2 valid
        req_twid_i[2*TWW +: TWW] = 3'd3;
        req_addr_i[2*AW +: AW]   = 5'd5;
        req_data_i[2*DW +: DW]   = 32'hDEADBEEF;
        req_valid_i = 3'b100;
        #1;
        chk("solo2_ready", req_ready_o, 3'b100);
        step();
        req_valid_i = '0;
        #1;
        chk("solo2_we", rd_w_en_o, 1);
        chk("solo2_twid", rd_twid_o, 3);
        chk("solo2_addr", rd_addr_o, 5);
        chk("solo2_data", rd_data_o, 32'hDEADBEEF);

        // All valid: rotation 0,1,2,0,1,2
        req_valid_i = 3'b111;
        for (int i = 0; i < 6; i++) begin
            #1;
            seq[i] = req_ready_o;
            step();
        end
        for (int i = 0; i < 6; i++) chk($sformatf("rr_seq%0d", i), seq[i], seq_exp[i]);
        chk("rr_back_to_back_we", rd_w_en_o, 1);

        // Requester 1 writes x0
        req_valid_i = 3'b010;
        req_addr_i[1*AW +: AW] = '0;
        #1;
        chk("x0_ready", req_ready_o, 3'b010);
        step();
        req_valid_i = '0;
        req_addr_i[1*AW +: AW] = 5'd9;
        #1;
        chk("x0_no_write", rd_w_en_o, 0);

        // Clear beats simultaneous writebacks
        req_valid_i = 3'b111;
        clr_valid_i = 1'b1;
        clr_twid_i  = 3'd6;
        #1;
        chk("clr_wins_clr_ready", clr_ready_o, 1);
        chk("clr_wins_req_ready", req_ready_o, 0);
        step();
        clr_valid_i = 1'b0;
        cnt = 0;
        for (int j = 1; j <= 32; j++) begin
            step();
            if (rd_w_en_o && rd_twid_o == 6 && rd_addr_o == AW'(j - 1) && rd_data_o == 0) cnt++;
        end
        chk("thr_clear_writes", cnt, 32);
        chk("rr_resume_ready", req_ready_o, 3'b100);
        step();
        req_valid_i = '0;

        repeat (3000) begin
            rand_inputs(2);
            step();
        end

        // Reset in the middle of a thread clear
        req_valid_i = '0;
        clr_valid_i = 1'b1;
        clr_twid_i  = 3'd5;
        step();
        clr_valid_i = 1'b0;
        repeat (10) step();
        #2;
        rst_i = 1'b0;
        req_valid_i = '1;
        clr_valid_i = 1'b1;
        #1;
        check_reset_vals("midclr");
        repeat (2) @(posedge clk);
        #1;
        req_valid_i = '0;
        clr_valid_i = 1'b0;
        rst_i = 1'b1;
        model_reset();
`ifdef MRV1_RF_INIT_CLEAR_EN
        step();
        chk("restart_we", rd_w_en_o, 1);
        chk("restart_addr0", {rd_twid_o, rd_addr_o}, 0);
        repeat (256) step();
`else
        req_valid_i = 3'b001;
        #1;
        chk("restart_ready0", req_ready_o, 3'b001);
        step();
`endif
        repeat (300) begin
            rand_inputs(3);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
